// File: rtl/line_fill_buffer_pkg.sv
// FUNCTIONS package for the line fill buffer: cache geometry constants,
// mask reduction helpers, a ceil-log2 helper and the fill FSM state type.
package line_fill_buffer_pkg;

  localparam int MINIMUM_ADDRESSIBLE_SIZE = 8;    // bits per addressable unit
  localparam int cache_block              = 512;  // bits per cache line

  // Widest mask the reduction helpers handle; narrower masks are zero-extended.
  localparam int FN_W = 512;

  typedef logic [cache_block-1:0]                            line_data_t;
  typedef logic [cache_block/MINIMUM_ADDRESSIBLE_SIZE-1:0]   byte_mask_t;

  typedef enum logic [1:0] {
    LFB_IDLE    = 2'd0,
    LFB_REQ     = 2'd1,
    LFB_FILL    = 2'd2,
    LFB_DELIVER = 2'd3
  } lfb_state_e;

  // AND of the low n bits of v; bits at or above n do not participate.
  function automatic logic and_itself(input logic [FN_W-1:0] v, input int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < FN_W; i++)
      if (i < n) r = r & v[i];
    return r;
  endfunction

  function automatic logic or_itself(input logic [FN_W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FN_W; i++) r = r | v[i];
    return r;
  endfunction

  function automatic int log(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/line_fill_buffer_fill_mask_tracker.sv
// Per-byte valid mask for the line being filled. Beats set a whole slice;
// fill_done looks ahead so the FSM can leave FILL on the last new beat.
module fill_mask_tracker
  import line_fill_buffer_pkg::*;
#(
  parameter  int LINE_BYTES = 64,
  parameter  int BEAT_BYTES = 8,
  localparam int NUM_BEATS  = LINE_BYTES / BEAT_BYTES,
  localparam int BIDX_W     = (NUM_BEATS > 1) ? log(NUM_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set_en,
  input  logic [BIDX_W-1:0] set_idx,
  input  logic [BIDX_W-1:0] query_idx,
  output logic              beat_present,
  output logic              line_full,
  output logic              fill_done
);

  logic [LINE_BYTES-1:0] mask_q;
  logic [LINE_BYTES-1:0] set_mask;

  always_comb begin
    set_mask = '0;
    if (set_en) set_mask[set_idx*BEAT_BYTES +: BEAT_BYTES] = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         mask_q <= '0;
    else if (clr)    mask_q <= '0;
    else             mask_q <= mask_q | set_mask;
  end

  assign beat_present = or_itself(FN_W'(mask_q[query_idx*BEAT_BYTES +: BEAT_BYTES]));
  assign line_full    = and_itself(FN_W'(mask_q), LINE_BYTES);
  assign fill_done    = and_itself(FN_W'(mask_q | set_mask), LINE_BYTES);

endmodule

// File: rtl/line_fill_buffer.sv
// Line fill buffer: requests a missing line, merges response beats in any
// order (first copy of a beat wins) and offers the full line to the cache.
// Optional critical-word bypass under FILL_CRITICAL_WORD_EN.
module line_fill_buffer
  import line_fill_buffer_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int LINE_BYTES = 64,
  parameter  int BEAT_BYTES = 8,
  localparam int OFF_W      = log(LINE_BYTES),
  localparam int BOFF_W     = log(BEAT_BYTES),
  localparam int NUM_BEATS  = LINE_BYTES / BEAT_BYTES,
  localparam int BIDX_W     = (NUM_BEATS > 1) ? log(NUM_BEATS) : 1,
  localparam int BEAT_W     = BEAT_BYTES * 8,
  localparam int LINE_W     = LINE_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [BIDX_W-1:0]     mem_rsp_idx,
  input  logic [BEAT_W-1:0]     mem_rsp_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [ADDR_WIDTH-1:0] line_addr,
  output logic [LINE_W-1:0]     line_data,
`ifdef FILL_CRITICAL_WORD_EN
  output logic                  cw_valid,
  output logic [BEAT_W-1:0]     cw_data,
`endif
  output logic                  busy
);

  if (!is_pow2(LINE_BYTES) || !is_pow2(BEAT_BYTES) ||
      LINE_BYTES < BEAT_BYTES || LINE_BYTES > FN_W) begin : g_bad_cfg
    $error("line_fill_buffer: LINE_BYTES/BEAT_BYTES must be powers of 2 with LINE_BYTES >= BEAT_BYTES");
  end

  lfb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_W-1:0]     data_q;
  logic                  mask_clr, beat_wr;
  logic                  beat_present, line_full, fill_done;

  fill_mask_tracker #(
    .LINE_BYTES (LINE_BYTES),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_mask (
    .clk          (clk),
    .rst          (rst),
    .clr          (mask_clr),
    .set_en       (beat_wr),
    .set_idx      (mem_rsp_idx),
    .query_idx    (mem_rsp_idx),
    .beat_present (beat_present),
    .line_full    (line_full),
    .fill_done    (fill_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LFB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    line_valid    = 1'b0;
    mask_clr      = 1'b0;
    beat_wr       = 1'b0;
    case (state_q)
      LFB_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          mask_clr = 1'b1;
          state_d  = LFB_REQ;
        end
      end
      LFB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = LFB_FILL;
      end
      LFB_FILL: begin
        // Duplicates are dropped so the first copy of each beat is kept.
        beat_wr = mem_rsp_valid && !beat_present;
        if (beat_wr && fill_done) state_d = LFB_DELIVER;
      end
      LFB_DELIVER: begin
        line_valid = 1'b1;
        if (line_ready) begin
          mask_clr = 1'b1;
          state_d  = LFB_IDLE;
        end
      end
      default: state_d = LFB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        addr_q <= '0;
    else if (miss_valid && miss_ready) addr_q <= {miss_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          data_q <= '0;
    else if (beat_wr) data_q[mem_rsp_idx*BEAT_W +: BEAT_W] <= mem_rsp_data;
  end

  assign mem_req_addr = addr_q;
  assign line_addr    = addr_q;
  assign line_data    = data_q;
  assign busy         = (state_q != LFB_IDLE);

  // line_full mirrors DELIVER entry; kept for observability only.
  logic unused_line_full;
  assign unused_line_full = line_full;

`ifdef FILL_CRITICAL_WORD_EN
  logic [BIDX_W-1:0] crit_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           crit_idx_q <= '0;
    else if (miss_valid && miss_ready) crit_idx_q <= BIDX_W'(miss_addr[OFF_W-1:0] >> BOFF_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_valid <= 1'b0;
      cw_data  <= '0;
    end else begin
      cw_valid <= beat_wr && (mem_rsp_idx == crit_idx_q);
      if (beat_wr && (mem_rsp_idx == crit_idx_q)) cw_data <= mem_rsp_data;
    end
  end
`else
  logic unused_low_addr;
  assign unused_low_addr = ^miss_addr[OFF_W-1:0];
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
// Self-checking bench for line_fill_buffer (64-byte line, 8-byte beats):
// directed scenarios followed by randomized fills against a beat-array model.
`timescale 1ns/1ps
module tb_line_fill_buffer;
  localparam int AW = 32;
  localparam int NB = 8;
  localparam int BW = 64;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          miss_valid = 1'b0, miss_ready;
  logic [AW-1:0] miss_addr = '0;
  logic          mem_req_valid, mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [2:0]    mem_rsp_idx = '0;
  logic [BW-1:0] mem_rsp_data = '0;
  logic          line_valid, line_ready = 1'b0;
  logic [AW-1:0] line_addr;
  logic [LW-1:0] line_data;
  logic          busy;
`ifdef FILL_CRITICAL_WORD_EN
  logic          cw_valid;
  logic [BW-1:0] cw_data;
`endif

  line_fill_buffer dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_idx(mem_rsp_idx), .mem_rsp_data(mem_rsp_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr), .line_data(line_data),
`ifdef FILL_CRITICAL_WORD_EN
    .cw_valid(cw_valid), .cw_data(cw_data),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which beats have arrived and the first data seen for each.
  logic [BW-1:0] m_beat [NB];
  bit            m_got  [NB];
  logic [AW-1:0] m_addr;
`ifdef FILL_CRITICAL_WORD_EN
  int            m_crit;
`endif

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
  endtask

  task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
  endtask

  task automatic chk_l(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
  endtask

  function automatic logic [LW-1:0] m_line();
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[i*BW +: BW] = m_beat[i];
    return r;
  endfunction

  function automatic logic m_full();
    logic r;
    r = 1'b1;
    for (int i = 0; i < NB; i++) r = r & m_got[i];
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    chk_b({tag, "_miss_ready"}, miss_ready, 1'b1);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_req_valid"}, mem_req_valid, 1'b0);
    chk_b({tag, "_line_valid"}, line_valid, 1'b0);
    chk_a({tag, "_line_addr"}, line_addr, '0);
    chk_l({tag, "_line_data"}, line_data, '0);
`ifdef FILL_CRITICAL_WORD_EN
    chk_b({tag, "_cw_valid"}, cw_valid, 1'b0);
    chk_l({tag, "_cw_data"}, LW'(cw_data), '0);
`endif
  endtask

  // Present a miss in IDLE, then hold the request for req_wait extra cycles.
  task automatic do_miss(input logic [AW-1:0] a, input int req_wait);
    chk_b("idle_miss_ready", miss_ready, 1'b1);
    chk_b("idle_busy", busy, 1'b0);
    miss_valid = 1'b1;
    miss_addr  = a;
    @(negedge clk);
    miss_valid = 1'b0;
    miss_addr  = $urandom;
    m_addr = a & 32'hFFFF_FFC0;
    for (int i = 0; i < NB; i++) m_got[i] = 1'b0;
`ifdef FILL_CRITICAL_WORD_EN
    m_crit = int'((a % 64) / 8);
`endif
    for (int i = 0; i <= req_wait; i++) begin
      chk_b("req_valid", mem_req_valid, 1'b1);
      chk_a("req_addr", mem_req_addr, m_addr);
      chk_b("req_miss_ready", miss_ready, 1'b0);
      chk_b("req_busy", busy, 1'b1);
      if (i == req_wait) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    chk_b("fill_req_valid", mem_req_valid, 1'b0);
  endtask

  task automatic do_beat(input int idx, input logic [BW-1:0] d);
    bit is_new;
    is_new = !m_got[idx];
    mem_rsp_valid = 1'b1;
    mem_rsp_idx   = 3'(idx);
    mem_rsp_data  = d;
    if (is_new) begin
      m_got[idx]  = 1'b1;
      m_beat[idx] = d;
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = {$urandom, $urandom};
    chk_b("beat_line_valid", line_valid, m_full());
`ifdef FILL_CRITICAL_WORD_EN
    chk_b("cw_valid", cw_valid, is_new && (idx == m_crit));
    if (is_new && (idx == m_crit)) chk_l("cw_data", LW'(cw_data), LW'(d));
`endif
  endtask

  // Hold line_ready low for hold cycles, then handshake and confirm IDLE.
  task automatic do_deliver(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk_b("dlv_line_valid", line_valid, 1'b1);
      chk_a("dlv_line_addr", line_addr, m_addr);
      chk_l("dlv_line_data", line_data, m_line());
      chk_b("dlv_miss_ready", miss_ready, 1'b0);
`ifdef FILL_CRITICAL_WORD_EN
      chk_b("dlv_cw_valid", cw_valid, 1'b0);
`endif
      @(negedge clk);
    end
    chk_b("hs_line_valid", line_valid, 1'b1);
    chk_a("hs_line_addr", line_addr, m_addr);
    chk_l("hs_line_data", line_data, m_line());
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    chk_b("post_line_valid", line_valid, 1'b0);
    chk_b("post_miss_ready", miss_ready, 1'b1);
    chk_b("post_busy", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] exp1;
    logic [BW-1:0] ones;
    int            ord [NB];
    int            j, t, k;

    ones = 64'h0101_0101_0101_0101;
    for (int b = 0; b < LW / 8; b++) exp1[b*8 +: 8] = 8'(b / 8 + 1);

    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_rel");

    // In-order fill
    do_miss(32'h0000_1234, 0);
    chk_a("s1_req_addr", m_addr, 32'h0000_1200);
    for (int i = 0; i < NB; i++) do_beat(i, ones * BW'(i + 1));
    chk_a("s1_line_addr", line_addr, 32'h0000_1200);
    chk_l("s1_line_data", line_data, exp1);
    do_deliver(0);

    // Out-of-order fill
    do_miss(32'h0000_1234, 2);
    ord = '{7, 3, 0, 5, 1, 6, 2, 4};
    for (int i = 0; i < NB; i++) do_beat(ord[i], ones * BW'(ord[i] + 1));
    chk_l("s2_line_data", line_data, exp1);
    do_deliver(1);

    // Duplicate beat keeps first data
    do_miss(32'h0000_8040, 1);
    do_beat(2, {8{8'hAA}});
    do_beat(2, {8{8'h55}});
    for (int i = 0; i < NB; i++) if (i != 2) do_beat(i, {$urandom, $urandom});
    chk_l("s3_beat2", LW'(line_data[2*BW +: BW]), LW'({8{8'hAA}}));
    do_deliver(0);

    // Backpressure, then an immediate new miss
    do_miss(32'hDEAD_BEEF, 0);
    for (int i = NB - 1; i >= 0; i--) do_beat(i, {$urandom, $urandom});
    do_deliver(5);
    do_miss(32'h0000_0040, 0);
    for (int i = 0; i < NB; i++) do_beat(i, {$urandom, $urandom});
    do_deliver(0);

    // Reset mid-fill
    do_miss(32'h1234_5678, 0);
    for (int i = 0; i < 4; i++) do_beat(i, {$urandom, $urandom});
    #2 rst = 1'b1;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NB; i++) m_got[i] = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_idx   = 3'd4;
    mem_rsp_data  = {8{8'h77}};
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check_reset_state("stray_beat");
    do_miss(32'h0000_2000, 0);
    for (int i = 0; i < NB; i++) do_beat(i, {$urandom, $urandom});
    do_deliver(0);

    // Critical word with duplicate
    do_miss(32'h0000_1228, 0);
    for (int i = 0; i < 5; i++) do_beat(i, {$urandom, $urandom});
    do_beat(5, 64'h0123_4567_89AB_CDEF);
    do_beat(5, 64'hFFFF_0000_FFFF_0000);
    do_beat(6, {$urandom, $urandom});
    do_beat(7, {$urandom, $urandom});
    do_deliver(0);

    // Randomized fills: shuffled order, gaps, duplicates, variable stalls
    for (int it = 0; it < 30; it++) begin
      do_miss($urandom, $urandom_range(2, 0));
      for (int i = 0; i < NB; i++) ord[i] = i;
      for (int i = NB - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
      for (int i = 0; i < NB; i++) begin
        if (i > 0 && $urandom_range(3, 0) == 0) begin
          k = $urandom_range(i - 1, 0);
          do_beat(ord[k], {$urandom, $urandom});
        end
        repeat ($urandom_range(1, 0)) begin
          @(negedge clk);
          chk_b("gap_line_valid", line_valid, 1'b0);
        end
        do_beat(ord[i], {$urandom, $urandom});
      end
      do_deliver($urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
